// File: rtl/sram_bank_sim_pkg.sv
// Shared types and helpers for the behavioural SRAM bank: FSM states,
// read-latency limits and the per-byte even-parity function.
package sram_bank_sim_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sram_bank_sim_rd_pipe.sv
// Read-return pipeline: RD_LAT stages of valid/data/perr. An asynchronous
// reset flushes everything in flight. The last data stage holds between strobes.
module sram_bank_sim_rd_pipe
  import sram_bank_sim_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_vld,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_perr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] dataout,
  output logic              rd_perr
);

  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  logic [LAT-1:0]             vld_pipe;
  logic [LAT-1:0]             perr_pipe;
  logic [LAT-1:0][DATA_W-1:0] data_pipe;

  // Data stages advance only behind a valid, so the output stage keeps the last word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      perr_pipe <= '0;
      data_pipe <= '0;
    end else begin
      vld_pipe[0]  <= req_vld;
      perr_pipe[0] <= req_perr & req_vld;
      if (req_vld) data_pipe[0] <= req_data;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        perr_pipe[i] <= perr_pipe[i-1];
        if (vld_pipe[i-1]) data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  assign rd_valid = vld_pipe[LAT-1];
  assign dataout  = data_pipe[LAT-1];
  assign rd_perr  = perr_pipe[LAT-1] & vld_pipe[LAT-1];

endmodule

// File: rtl/sram_bank_sim.sv
// Behavioural SRAM bank: byte-enable writes, read-first collisions, RD_LAT read
// latency and a zero-fill clear after reset. Optional SRAM_BANK_SIM_PARITY_EN.
module sram_bank_sim
  import sram_bank_sim_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   addr_sel,
  input  logic [DATA_W/8-1:0] byte_sel,
  input  logic                read_enable,
  input  logic                write_enable,
  input  logic [DATA_W-1:0]   datain,
  input  logic                err_inject,
  output logic                ready,
  output logic [DATA_W-1:0]   dataout,
  output logic                rd_valid,
  output logic                rd_perr
);

  localparam int NB = DATA_W / 8;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              ready_q;
  logic              rd_acc, wr_acc;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic              perr_p0;

  // Control: FSM, clear counter and registered ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_q == RUN);
      if (state_q == CLEAR) clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  assign ready  = ready_q;
  assign rd_acc = ready_q & read_enable;
  assign wr_acc = ready_q & write_enable;

  // Stage p0: array access. Nonblocking update makes a same-cycle read see old data.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++)
        if (byte_sel[i]) mem[addr_sel][8*i +: 8] <= datain[8*i +: 8];
    end
    if (rd_acc) data_p0 <= mem[addr_sel];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= rd_acc;
  end

`ifdef SRAM_BANK_SIM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];

  function automatic logic [NB-1:0] word_parity(input logic [DATA_W-1:0] w);
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) p[i] = byte_parity(w[8*i +: 8]);
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      par_mem[clr_cnt_q] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++)
        if (byte_sel[i]) par_mem[addr_sel][i] <= byte_parity(datain[8*i +: 8]) ^ err_inject;
    end
    if (rd_acc) perr_p0 <= |(par_mem[addr_sel] ^ word_parity(mem[addr_sel]));
  end
`else
  logic unused_err_inject;
  assign unused_err_inject = err_inject;
  assign perr_p0 = 1'b0;
`endif

  // Stages p1..pRD_LAT: return pipeline.
  sram_bank_sim_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .reset    (reset),
    .req_vld  (vld_p0),
    .req_data (data_p0),
    .req_perr (perr_p0),
    .rd_valid (rd_valid),
    .dataout  (dataout),
    .rd_perr  (rd_perr)
  );

endmodule

// File: tb/tb_sram_bank_sim.sv
// Scoreboard bench for sram_bank_sim (RD_LAT=3, DEPTH=16); parity expectations
// follow SRAM_BANK_SIM_PARITY_EN when the bench is built with it.
module tb_sram_bank_sim;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int RD_LAT = 3;
  localparam int ADDR_W = 4;
  localparam int NB     = 4;
`ifdef SRAM_BANK_SIM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] addr_sel;
  logic [NB-1:0]     byte_sel;
  logic              read_enable;
  logic              write_enable;
  logic [DATA_W-1:0] datain;
  logic              err_inject;
  logic              ready;
  logic [DATA_W-1:0] dataout;
  logic              rd_valid;
  logic              rd_perr;

  sram_bank_sim #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .addr_sel     (addr_sel),
    .byte_sel     (byte_sel),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .datain       (datain),
    .err_inject   (err_inject),
    .ready        (ready),
    .dataout      (dataout),
    .rd_valid     (rd_valid),
    .rd_perr      (rd_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              perr;
    int                due;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] model [DEPTH];
  logic [NB-1:0]     pflag [DEPTH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    for (int a = 0; a < DEPTH; a++) begin
      model[a] = '0;
      pflag[a] = '0;
    end
  endtask

  // One request per clock; expectation pushed when the request is driven.
  task automatic issue(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                       input logic [NB-1:0] be, input logic [DATA_W-1:0] d, input bit inj);
    exp_t e;
    @(negedge clk);
    read_enable  = rd;
    write_enable = wr;
    addr_sel     = a;
    byte_sel     = be;
    datain       = d;
    err_inject   = inj;
    if (rd) begin
      e.data = model[a];
      e.perr = PAR && (pflag[a] != '0);
      e.due  = cyc + 1 + RD_LAT;
      sb.push_back(e);
    end
    if (wr)
      for (int i = 0; i < NB; i++)
        if (be[i]) begin
          model[a][8*i +: 8] = d[8*i +: 8];
          pflag[a][i]        = inj;
        end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) issue(0, 0, '0, '0, '0, 0);
  endtask

  // Called right after reset deasserts; keeps requests asserted during clear.
  task automatic wait_clear();
    int n;
    read_enable  = 1'b1;
    write_enable = 1'b1;
    addr_sel     = '0;
    byte_sel     = '1;
    datain       = '1;
    n = 0;
    for (int k = 0; k < DEPTH + 10; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (ready) break;
    end
    chk("clear_len", n, DEPTH + 1);
    model_zero();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rd_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rd_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rd_data", dataout, e.data);
        chk("rd_perr", rd_perr, e.perr);
        chk("rd_latency", cyc, e.due);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    addr_sel     = '0;
    byte_sel     = '0;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    datain       = '0;
    err_inject   = 1'b0;
    model_zero();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_dataout", dataout, 0);
    chk("rst_rd_perr", rd_perr, 0);

    @(negedge clk);
    reset = 1'b0;
    wait_clear();

    issue(1, 0, 5, '0, '0, 0);
    idle(RD_LAT + 1);

    issue(0, 1, 3, 4'b1111, 32'hDEADBEEF, 0);
    issue(0, 1, 3, 4'b0010, 32'h0000AA00, 0);
    issue(1, 0, 3, '0, '0, 0);
    issue(0, 1, 3, 4'b0000, 32'hFFFFFFFF, 0);
    issue(1, 0, 3, 4'b1111, '0, 0);

    issue(0, 1, 7, 4'b1111, 32'h11111111, 0);
    issue(1, 1, 7, 4'b1111, 32'h22222222, 0);
    issue(1, 0, 7, '0, '0, 0);

    issue(0, 1, 0, 4'b1111, 32'hA0A0A0A0, 0);
    issue(0, 1, 1, 4'b1111, 32'hB1B1B1B1, 0);
    issue(0, 1, 2, 4'b1111, 32'hC2C2C2C2, 0);
    issue(1, 0, 0, '0, '0, 0);
    issue(1, 0, 1, '0, '0, 0);
    issue(1, 0, 2, '0, '0, 0);
    idle(RD_LAT + 4);
    chk("dataout_hold", dataout, model[2]);

    issue(0, 1, 4, 4'b1111, 32'h44444444, 0);
    issue(1, 0, 4, '0, '0, 0);
    issue(1, 0, 5, '0, '0, 0);
    @(negedge clk);
    read_enable  = 1'b0;
    write_enable = 1'b0;
    reset        = 1'b1;
    sb.delete();
    #1;
    chk("midrd_rd_valid", rd_valid, 0);
    chk("midrd_dataout", dataout, 0);
    chk("midrd_ready", ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midclr_ready", ready, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_clear();
    for (int a = 0; a < DEPTH; a++) issue(1, 0, a[ADDR_W-1:0], '0, '0, 0);

    issue(0, 1, 9, 4'b1111, 32'h5A5A1234, 1);
    issue(1, 0, 9, '0, '0, 0);
    issue(0, 1, 9, 4'b1111, 32'h5A5A1234, 0);
    issue(1, 0, 9, '0, '0, 0);

    idle(RD_LAT + 3);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_bank_sim.md
# sram_bank_sim

Parametrised behavioural SRAM bank for simulation: byte-enable writes, configurable-latency reads with a valid strobe, defined read/write collision behaviour and a hardware clear sequence after reset. Instantiated wherever the core needs instruction/data memory in simulation, in place of a bit-cell-level SRAM, and matches that SRAM's externally visible behaviour.

## Interface
- DATA_W, 32: data width in bits; multiple of 8.
- DEPTH, 128: number of words; power of two, ≥ 2.
- RD_LAT, 1: read latency in cycles from accepted read to rd_valid; 1..4.
- ADDR_W, $clog2(DEPTH): address width (derived; do not override).
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr_sel  in  ADDR_W  word address for the current request.
- byte_sel  in  DATA_W/8  per-byte write enables; ignored on reads.
- read_enable  in  1  read request.
- write_enable  in  1  write request.
- datain  in  DATA_W  write data.
- err_inject  in  1  flips stored parity of written bytes (parity build only; ignored otherwise).
- ready  out  1  high when requests are accepted; reset 0.
- dataout  out  DATA_W  read data; reset 0.
- rd_valid  out  1  one-cycle strobe, dataout carries a new read result; reset 0.
- rd_perr  out  1  parity error on the word returned with rd_valid; reset 0.

## Operation
- FSM states: CLEAR, RUN.
- Reset asserted: FSM → CLEAR, clear counter → 0, read pipeline flushed, all outputs 0.
- CLEAR: one word per cycle written with all-zero data (and correct parity), addresses 0..DEPTH-1 ascending; after word DEPTH-1 is written → RUN. ready = 0 throughout; requests in CLEAR are dropped, not queued.
- RUN: ready = 1. Requests accepted each cycle.
- Write: for each i with byte_sel[i]=1, mem[addr_sel][8i+7:8i] ← datain byte i; other bytes unchanged. byte_sel = 0 is a legal no-op.
- Read: full word only; byte_sel has no effect.
- read_enable and write_enable together: both performed, same or different address; read returns the pre-write contents (read-first).
- Back-to-back reads: one result per cycle, returned in order.
- dataout holds the last returned word until the next rd_valid; it is not cleared by idle cycles.
- Address is always in range (ADDR_W bits exactly cover DEPTH); no wrap logic.

## Timing
- Clear sequence: ready rises in the cycle after the DEPTH-th clear write, i.e. DEPTH+1 clk edges after reset deasserts.
- Write visible to a read accepted on the following edge.
- Read accepted at edge N → rd_valid high and dataout valid after edge N+RD_LAT, for exactly one cycle per read.
- Reset mid-read: in-flight results discarded; no rd_valid after reset. Reset mid-clear: clear restarts at address 0.
- Memory contents outside the clear sequence are retained across reset only until overwritten by the clear.

## Configuration
- SRAM_BANK_SIM_PARITY_EN defined: one even-parity bit stored per byte; computed on write (inverted when err_inject=1); checked on read; rd_perr = OR of byte parity mismatches, aligned with rd_valid, 0 when rd_valid=0.
- Not defined: no parity storage; rd_perr tied 0; err_inject unused.

## Structure
- Package sram_bank_sim_pkg: FSM state enum (CLEAR, RUN), byte-parity function, RD_LAT range constants.
- One sub-module sram_bank_sim_rd_pipe: RD_LAT-deep valid/data/perr shift pipeline with async reset flush; top holds array, FSM and write logic.

## Test plan
- Reset, deassert, count cycles: ready = 0 for DEPTH cycles, then 1; read addr 5 → dataout 0x00000000, rd_valid after RD_LAT.
- Write 0xDEADBEEF byte_sel 4'b1111 to addr 3, then byte_sel 4'b0010 datain 0x0000AA00 → read addr 3 returns 0xDEADAAEF.
- Read and write addr 7 same cycle (old 0x11111111, new 0x22222222, all bytes) → read returns 0x11111111; next read returns 0x22222222.
- RD_LAT=3, reads addr 0,1,2 on consecutive cycles → three consecutive rd_valid strobes with matching data in order, dataout held afterwards.
- Assert reset with two reads in flight and during CLEAR → no rd_valid, outputs 0, clear restarts and all words read back 0.
- Parity build: write addr 9 with err_inject=1 → read flags rd_perr=1 with rd_valid; rewrite with err_inject=0 → rd_perr=0.
